// File: rtl/sprite_view.sv
// sprite_view: raster-to-sprite-ROM addressing with direction mirroring/rotation and animation frames.
// Define SPRITE_ANIM_EN to enable the animation counter; otherwise frame is fixed at 0.
module sprite_view #(
    parameter int          SPR_W      = 30,
    parameter int          SPR_H      = 30,
    parameter int          COORD_W    = 10,
    parameter int          NFRAMES    = 4,
    parameter int          FRAME_HOLD = 8,
    parameter logic [11:0] TRANSP     = 12'h000,
    parameter int          AW         = $clog2(NFRAMES * SPR_W * SPR_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] vC,
    input  logic [COORD_W-1:0] hC,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic [3:0]         direction,
    input  logic               moving,
    input  logic               frame_tick,
    output logic [AW-1:0]      rom_addr,
    input  logic [11:0]        rom_data,
    output logic               pix_fill,
    output logic [11:0]        color_data
);

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b1000;

    localparam int FW         = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int HW         = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int FRAME_SIZE = SPR_W * SPR_H;

    logic [COORD_W-1:0] col_off;
    logic [COORD_W-1:0] row_off;
    logic               in_box;

    // Unsigned wrap pushes raster positions left of / above the sprite far out of range.
    assign col_off = hC - xpos;
    assign row_off = vC - ypos;
    assign in_box  = (col_off < COORD_W'(SPR_W)) && (row_off < COORD_W'(SPR_H));

    logic [3:0] dir_q;

    // Orientation only changes at the frame boundary so a sprite never tears mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q <= DIR_RIGHT;
        end else if (frame_tick && $onehot(direction)) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            dir_q <= direction;
        end
    end

    logic [FW-1:0] frame;

`ifdef SPRITE_ANIM_EN
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            frame    <= '0;
        end else if (frame_tick && moving) begin
            if (hold_cnt == HW'(FRAME_HOLD - 1)) begin
                hold_cnt <= '0;
                frame    <= (frame == FW'(NFRAMES - 1)) ? '0 : frame + 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_moving;

    assign frame         = '0;
    assign unused_moving = moving;
`endif

    logic [AW-1:0] col_a;
    logic [AW-1:0] row_a;
    logic [AW-1:0] src_row;
    logic [AW-1:0] src_col;
    logic [AW-1:0] addr_next;

    assign col_a = AW'(col_off);
    assign row_a = AW'(row_off);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        src_row = row_a;
        src_col = col_a;
        case (dir_q)
            DIR_LEFT: begin
                src_col = AW'(SPR_W - 1) - col_a;
            end
            DIR_DOWN: begin
                src_row = col_a;
                src_col = row_a;
            end
            DIR_UP: begin
                src_row = AW'(SPR_W - 1) - col_a;
                src_col = row_a;
            end
            default: ;
        endcase
    end

    // Exact at AW bits: every in-box address is below NFRAMES*SPR_W*SPR_H.
    assign addr_next = AW'(frame) * AW'(FRAME_SIZE) + src_row * AW'(SPR_W) + src_col;

    logic in_d1;
    logic in_d2;
    logic opaque;

    assign opaque = in_d2 && (rom_data != TRANSP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr   <= '0;
            in_d1      <= 1'b0;
            in_d2      <= 1'b0;
            pix_fill   <= 1'b0;
            color_data <= '0;
        end else begin
            rom_addr   <= in_box ? addr_next : '0;
            in_d1      <= in_box;
            in_d2      <= in_d1;
            pix_fill   <= opaque;
            color_data <= opaque ? rom_data : 12'h000;
        end
    end

endmodule

// File: tb/tb_sprite_view.sv
// Scoreboard bench for sprite_view: a model computes expected ROM address and pixel per raster input,
// a negedge monitor compares when each result is due. Handles SPRITE_ANIM_EN defined or not.
`timescale 1ns/1ps
module tb_sprite_view;

    localparam int          SW     = 30;
    localparam int          NF     = 4;
    localparam int          FH     = 8;
    localparam int          CMASK  = 1023;
    localparam int          RSZ    = NF * SW * SW;
    localparam logic [11:0] TRANSP = 12'h000;

    localparam logic [3:0] D_R = 4'b0001;
    localparam logic [3:0] D_L = 4'b0010;
    localparam logic [3:0] D_D = 4'b0100;
    localparam logic [3:0] D_U = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  vC = '0, hC = '0, xpos = '0, ypos = '0;
    logic [3:0]  direction = D_R;
    logic        moving = 1'b0;
    logic        frame_tick = 1'b0;
    logic [11:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic        pix_fill;
    logic [11:0] color_data;

    always #5 clk = ~clk;

    sprite_view dut (
        .clk(clk), .rst(rst), .vC(vC), .hC(hC), .xpos(xpos), .ypos(ypos),
        .direction(direction), .moving(moving), .frame_tick(frame_tick),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_fill(pix_fill), .color_data(color_data)
    );

    logic [11:0] rom_mem [RSZ];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int addr; } aexp_t;
    typedef struct { int due; logic fill; logic [11:0] col; } pexp_t;
    aexp_t addr_q[$];
    pexp_t pix_q[$];

    // Reference state: latched direction and count of ticks seen while moving.
    logic [3:0] dir_m = D_R;
    int         nticks = 0;
    int         frame_m = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        dir_m   = D_R;
        nticks  = 0;
        frame_m = 0;
    endtask

    // Present one raster pixel for one clock and queue its expected results.
    task automatic px(input int h, input int v, input int x, input int y,
                      input logic [3:0] d, input logic mv, input logic tk);
        int c, r, sr, sc, ea;
        bit in;
        logic [11:0] col;
        aexp_t ae;
        pexp_t pe;
        @(negedge clk);
        hC = 10'(h); vC = 10'(v); xpos = 10'(x); ypos = 10'(y);
        direction = d; moving = mv; frame_tick = tk;
        c  = (h - x) & CMASK;
        r  = (v - y) & CMASK;
        in = (c < SW) && (r < SW);
        if (dir_m == D_L)      begin sr = r;          sc = SW - 1 - c; end
        else if (dir_m == D_D) begin sr = c;          sc = r;          end
        else if (dir_m == D_U) begin sr = SW - 1 - c; sc = r;          end
        else                   begin sr = r;          sc = c;          end
        ea  = in ? frame_m * SW * SW + sr * SW + sc : 0;
        col = in ? rom_mem[ea] : 12'h000;
        ae.due = cyc + 1; ae.addr = ea;
        pe.due = cyc + 3; pe.fill = in && (col != TRANSP); pe.col = pe.fill ? col : 12'h000;
        addr_q.push_back(ae);
        pix_q.push_back(pe);
        if (tk) begin
            if ($countones(d) == 1) dir_m = d;
`ifdef SPRITE_ANIM_EN
            if (mv) nticks++;
            frame_m = (nticks / FH) % NF;
`endif
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        frame_tick = 1'b0;
        while ((addr_q.size() + pix_q.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", addr_q.size() + pix_q.size(), 0);
    endtask

    task automatic fill_rom(input int mode, input logic [11:0] val);
        for (int i = 0; i < RSZ; i++)
            rom_mem[i] = (mode == 0) ? val
                       : (($urandom_range(0, 3) == 0) ? TRANSP : 12'($urandom));
    endtask

    aexp_t ae_m;
    pexp_t pe_m;
    always @(negedge clk) begin
        if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
            ae_m = addr_q.pop_front();
            check("rom_addr", int'(rom_addr), ae_m.addr);
        end
        if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            pe_m = pix_q.pop_front();
            check("pix_fill", int'(pix_fill), int'(pe_m.fill));
            check("color_data", int'(color_data), int'(pe_m.col));
        end
    end

    initial begin
        fill_rom(0, 12'hF00);

        // Reset with arbitrary inputs
        repeat (5) begin
            @(negedge clk);
            hC = 10'($urandom); vC = 10'($urandom); xpos = hC; ypos = vC;
            direction = 4'($urandom); moving = 1'b1; frame_tick = 1'b1;
        end
        @(negedge clk);
        check("reset_pix_fill", int'(pix_fill), 0);
        check("reset_color", int'(color_data), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        frame_tick = 1'b0; moving = 1'b0; direction = D_R;
        rst = 1'b1;

        // Bounds with an all-F00 ROM; first pixel also confirms right/frame 0 after reset
        px(105, 52, 100, 50, D_R, 0, 0);
        px(100, 50, 100, 50, D_R, 0, 0);
        px(130, 50, 100, 50, D_R, 0, 0);
        px(99,  50, 100, 50, D_R, 0, 0);
        px(129, 79, 100, 50, D_R, 0, 0);
        px(100, 80, 100, 50, D_R, 0, 0);
        px(3,   50, 1020, 50, D_R, 0, 0);
        px(100, 49, 100, 50, D_R, 0, 0);

        // Reset mid-line discards in-flight pixels
        px(100, 50, 100, 50, D_R, 0, 0);
        px(101, 50, 100, 50, D_R, 0, 0);
        px(102, 50, 100, 50, D_R, 0, 0);
        px(103, 50, 100, 50, D_R, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_pix_fill", int'(pix_fill), 0);
        check("midreset_color", int'(color_data), 0);
        check("midreset_rom_addr", int'(rom_addr), 0);
        addr_q.delete();
        pix_q.delete();
        model_reset();
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Orientation at offset r=2, c=5
        fill_rom(1, 12'h000);
        px(205, 302, 200, 300, D_R, 0, 0);
        px(0, 0, 200, 300, D_L, 0, 1);
        px(205, 302, 200, 300, D_L, 0, 0);
        px(0, 0, 200, 300, D_D, 0, 1);
        px(205, 302, 200, 300, D_D, 0, 0);
        px(0, 0, 200, 300, D_U, 0, 1);
        px(205, 302, 200, 300, D_U, 0, 0);

        // Direction latch: no tick, then non-one-hot values with ticks
        px(205, 302, 200, 300, D_R, 0, 0);
        px(0, 0, 200, 300, 4'b0011, 0, 1);
        px(205, 302, 200, 300, 4'b0011, 0, 0);
        px(0, 0, 200, 300, 4'b0000, 0, 1);
        px(205, 302, 200, 300, D_L, 0, 0);

        // Animation: 8 ticks -> frame 1, 32 ticks -> frame 0, idle ticks hold
        px(0, 0, 200, 300, D_R, 0, 1);
        for (int i = 0; i < 8; i++) px(0, 0, 200, 300, D_R, 1, 1);
        px(205, 302, 200, 300, D_R, 1, 0);
        for (int i = 0; i < 24; i++) px(0, 0, 200, 300, D_R, 1, 1);
        px(205, 302, 200, 300, D_R, 1, 0);
        for (int i = 0; i < 8; i++) px(0, 0, 200, 300, D_R, 1, 1);
        for (int i = 0; i < 10; i++) px(0, 0, 200, 300, D_R, 0, 1);
        px(205, 302, 200, 300, D_R, 0, 0);
        px(0, 0, 200, 300, D_D, 1, 1);
        px(205, 302, 200, 300, D_D, 1, 0);
        drain();

        // Transparency
        fill_rom(0, 12'h000);
        px(210, 310, 200, 300, D_D, 0, 0);
        drain();
        fill_rom(0, 12'h0F0);
        px(210, 310, 200, 300, D_D, 0, 0);
        drain();

        // Randomised traffic near the sprite box, including wrap and invalid directions
        fill_rom(1, 12'h000);
        for (int i = 0; i < 1500; i++) begin
            int x, y;
            logic [3:0] d;
            x = $urandom_range(0, CMASK);
            y = $urandom_range(0, CMASK);
            d = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            px((x + $urandom_range(0, 40) - 5) & CMASK, (y + $urandom_range(0, 40) - 5) & CMASK,
               x, y, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
